// File: rtl/sim_run_ctrl.sv
// sim_run_ctrl: run control for the chip-level simulation harness.
// It releases several reset channels one after another, keeps a free-running
// cycle counter, and captures pass / fail / timeout into sticky registered
// status outputs.
// The watchdog is built only when SIM_RUN_CTRL_WATCHDOG_EN is defined.
// Without it, max_cycle is ignored and timeout stays 0.
module sim_run_ctrl #(
  parameter int NUM_RST     = 3,
  parameter int RST_HOLD    = 4,
  parameter int RST_STAGGER = 2,
  parameter int CNT_W       = 64,
  parameter int EXIT_W      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CNT_W-1:0]  max_cycle,
  input  logic              exit_valid,
  input  logic [EXIT_W-1:0] exit_code,
  output logic [NUM_RST-1:0] rst_out,
  output logic              running,
  output logic [CNT_W-1:0]  cycle_cnt,
  output logic              done,
  output logic              fail,
  output logic              timeout,
  output logic [EXIT_W-1:0] fail_code
);

  localparam int REL_MAX = RST_HOLD + (NUM_RST - 1) * RST_STAGGER;
  localparam int RW      = (REL_MAX > 1) ? $clog2(REL_MAX + 1) : 1;

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    RELEASE = 2'd1,
    RUN     = 2'd2,
    DONE    = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [RW-1:0]      rel_cnt_q, rel_cnt_d;
  logic [NUM_RST-1:0] rst_out_q, rst_out_d;
  logic [CNT_W-1:0]   cycle_cnt_q, cycle_cnt_d;
  logic               running_q, running_d;
  logic               done_q, done_d;
  logic               fail_q, fail_d;
  logic               timeout_q, timeout_d;
  logic [EXIT_W-1:0]  fail_code_q, fail_code_d;

  logic [CNT_W-1:0]   cnt_inc_s;
  logic               wdog_s;

  // Saturating next value of the cycle counter and the watchdog fire condition
  always_comb begin
    if (cycle_cnt_q == {CNT_W{1'b1}}) begin
      cnt_inc_s = cycle_cnt_q;
    end else begin
      cnt_inc_s = cycle_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
`ifdef SIM_RUN_CTRL_WATCHDOG_EN
    wdog_s = (max_cycle != {CNT_W{1'b0}}) && (cnt_inc_s == max_cycle) &&
             (state_q != DONE);
`else
    // max_cycle is referenced only so it is not a dangling input
    wdog_s = (|max_cycle) & 1'b0;
`endif
  end

  // State register plus all output and datapath flops
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= HOLD;
      rel_cnt_q   <= {RW{1'b0}};
      rst_out_q   <= {NUM_RST{1'b1}};
      cycle_cnt_q <= {CNT_W{1'b0}};
      running_q   <= 1'b0;
      done_q      <= 1'b0;
      fail_q      <= 1'b0;
      timeout_q   <= 1'b0;
      fail_code_q <= {EXIT_W{1'b0}};
    end else begin
      state_q     <= state_d;
      rel_cnt_q   <= rel_cnt_d;
      rst_out_q   <= rst_out_d;
      cycle_cnt_q <= cycle_cnt_d;
      running_q   <= running_d;
      done_q      <= done_d;
      fail_q      <= fail_d;
      timeout_q   <= timeout_d;
      fail_code_q <= fail_code_d;
    end
  end

  // Next-state: release progress, then run until exit or watchdog; exit beats watchdog
  always_comb begin
    state_d = state_q;
    case (state_q)
      HOLD: begin
        if (wdog_s) begin
          state_d = DONE;
        end else if (rst_out_d == {NUM_RST{1'b0}}) begin
          state_d = RUN;
        end else if (!rst_out_d[0]) begin
          state_d = RELEASE;
        end else begin
          state_d = HOLD;
        end
      end
      RELEASE: begin
        if (wdog_s) begin
          state_d = DONE;
        end else if (rst_out_d == {NUM_RST{1'b0}}) begin
          state_d = RUN;
        end else begin
          state_d = RELEASE;
        end
      end
      RUN: begin
        if (exit_valid || wdog_s) begin
          state_d = DONE;
        end else begin
          state_d = RUN;
        end
      end
      DONE:    state_d = DONE;
      default: state_d = HOLD;
    endcase
  end

  // Output next values: release schedule, cycle count, sticky status capture
  always_comb begin
    rel_cnt_d   = rel_cnt_q;
    rst_out_d   = rst_out_q;
    done_d      = done_q;
    fail_d      = fail_q;
    timeout_d   = timeout_q;
    fail_code_d = fail_code_q;

    if (state_q != DONE) begin
      cycle_cnt_d = cnt_inc_s;
    end else begin
      cycle_cnt_d = cycle_cnt_q;
    end

    if ((state_q == HOLD) || (state_q == RELEASE)) begin
      rel_cnt_d = rel_cnt_q + {{(RW-1){1'b0}}, 1'b1};
      for (int i = 0; i < NUM_RST; i++) begin
        if (rel_cnt_d == RW'(RST_HOLD + i * RST_STAGGER)) begin
          rst_out_d[i] = 1'b0;
        end else begin
          rst_out_d[i] = rst_out_q[i];
        end
      end
    end else begin
      rel_cnt_d = rel_cnt_q;
    end

    if ((state_q == RUN) && exit_valid) begin
      done_d = 1'b1;
      if (exit_code != {EXIT_W{1'b0}}) begin
        fail_d      = 1'b1;
        fail_code_d = exit_code;
      end else begin
        fail_d      = 1'b0;
      end
    end else if (wdog_s) begin
      done_d      = 1'b1;
      fail_d      = 1'b1;
      timeout_d   = 1'b1;
      fail_code_d = {EXIT_W{1'b1}};
    end else begin
      done_d      = done_q;
    end

    running_d = (state_d == RUN);
  end

  assign rst_out   = rst_out_q;
  assign running   = running_q;
  assign cycle_cnt = cycle_cnt_q;
  assign done      = done_q;
  assign fail      = fail_q;
  assign timeout   = timeout_q;
  assign fail_code = fail_code_q;

endmodule
